pipe_field_render: RTL and testbench
====================================

Name: pipe_field_render

Overview:
Pixel-stage renderer that sits directly downstream of the VGA timing generator. It consumes h_count/v_count/bright/h_sync/v_sync and owns two scrolling obstacle pipes. Pipe gaps are randomised by an LFSR, and a pass counter tracks pipes that clear the bird column. It outputs registered 8-bit RGB with syncs delayed to match, plus a pipe-hit pixel flag for collision logic.

Parameters:
PIPE_WIDTH, 40, pipe width in pixels
GAP_HEIGHT, 120, vertical opening in pixels
SCROLL_STEP, 2, pixels moved left per enabled frame
BIRD_X, 160, screen column used for pass counting
GROUND_Y, 448, first ground row
LFSR_SEED, 8'hA5, LFSR reset value (nonzero)

Ports:
clock  input  1  system/pixel clock, all logic on posedge
reset  input  1  synchronous, active-high reset
enable  input  1  game running; when low, pipes are frozen
h_count  input  10  pixel column from timing generator
v_count  input  10  line from timing generator
bright  input  1  active-video flag
h_sync  input  1  active-low hsync
v_sync  input  1  active-low vsync
red  output  3  pixel red
green  output  3  pixel green
blue  output  2  pixel blue
h_sync_out  output  1  h_sync delayed 1 cycle
v_sync_out  output  1  v_sync delayed 1 cycle
bright_out  output  1  bright delayed 1 cycle
pipe_pixel  output  1  current output pixel is pipe body (bright and not ground)
frame_tick  output  1  one-cycle pulse per frame
score  output  8  pipes passed, saturating

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clock.
- Reset values: red/green/blue=0, h_sync_out=1, v_sync_out=1, bright_out=0, pipe_pixel=0, frame_tick=0, score=0. Pipe x[0]=640, x[1]=980, gap_y[0]=gap_y[1]=200, lfsr=LFSR_SEED.
- Reset mid-frame: takes effect on the next edge and overrides everything, including a coincident frame event.
- Pipe x is 11-bit signed: the left edge in screen columns. A pipe is visible where x <= h < x+PIPE_WIDTH. All compares are signed, with inputs zero-extended.
- Frame event:
  - Fires when h_count==0 and v_count==480 (start of vertical blank).
  - frame_tick=1 on the following cycle only.
  - All state updates below commit on that same edge.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances on every frame event regardless of enable.
- Scroll, on a frame event with enable=1, independently per pipe:
  - nx = x - SCROLL_STEP.
  - If nx <= -PIPE_WIDTH: x <= nx + 680 and gap_y <= 48 + lfsr (the pre-advance value). Both pipes may respawn in the same frame; each then takes the same lfsr value.
  - Otherwise x <= nx.
  - enable=0: x and gap_y hold.
- Score:
  - Per pipe, a pass occurs when (x+PIPE_WIDTH) > BIRD_X and (nx+PIPE_WIDTH) <= BIRD_X, evaluated on an enabled scroll.
  - Add 0, 1 or 2; saturate at 255. Only reset clears score.
- Pixel pipeline, 1-cycle latency (registered from the current inputs):
  - bright=0: RGB=0, pipe_pixel=0.
  - Else if v_count >= GROUND_Y: ground, r=5, g=3, b=0.
  - Else if h is inside either pipe and v is outside [gap_y, gap_y+GAP_HEIGHT): pipe_pixel=1. Edge columns (h==x or h==x+PIPE_WIDTH-1) are r=0, g=3, b=0; interior is r=0, g=6, b=0.
  - Else: sky, r=2, g=6, b=3.
  - h_sync_out, v_sync_out and bright_out are the inputs delayed by exactly 1 cycle, aligned with RGB.
- Positions change only at the frame event, which falls in vertical blank, so the display is tear-free.

Test Plan:
- Reset then free-run the timing generator -> first frame_tick one cycle after h=0,v=480. Outputs are sky-coloured when bright, 0 in blank. Sync outputs lag the inputs by exactly 1 clock.
- enable=1, run 60 frames -> x[0]=520. Input h=530,v=10 gives RGB 0/6/0 and pipe_pixel=1 next cycle. h=520 gives 0/3/0. h=530,v=250 (in gap) gives sky.
- Run 260 enabled frames -> score increments to 1 on frame 260, when x[0] reaches 120. Pipe1 passes at frame 430, giving score=2.
- Run 340 enabled frames -> x[0] respawns to 640 with gap_y[0]=48 + the LFSR value at that event. Gap stays within 48..303.
- enable=0 for 10 frames -> x and score unchanged, LFSR still advances 10 steps. Pixel at v=460 is ground 5/3/0 even inside a pipe column.
- Assert reset mid-line, including on a frame-event cycle -> next cycle all outputs and state hold their reset values and score=0.

Source files
------------

// File: rtl/pipe_field_render_if.sv
// Video-side bundle for the pipe field renderer: timing inputs from the VGA
// generator and the registered pixel/status outputs.
interface pipe_field_render_if;
    logic       enable;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       bright;
    logic       h_sync;
    logic       v_sync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       h_sync_out;
    logic       v_sync_out;
    logic       bright_out;
    logic       pipe_pixel;
    logic       frame_tick;
    logic [7:0] score;

    modport master (
        output enable, h_count, v_count, bright, h_sync, v_sync,
        input  red, green, blue, h_sync_out, v_sync_out, bright_out,
               pipe_pixel, frame_tick, score
    );

    modport slave (
        input  enable, h_count, v_count, bright, h_sync, v_sync,
        output red, green, blue, h_sync_out, v_sync_out, bright_out,
               pipe_pixel, frame_tick, score
    );
endinterface

// File: rtl/pipe_field_render.sv
// Two scrolling obstacle pipes with LFSR-placed gaps, a saturating pass
// counter, and a 1-cycle registered pixel stage behind the VGA timing generator.
module pipe_field_render #(
    parameter int PIPE_WIDTH  = 40,
    parameter int GAP_HEIGHT  = 120,
    parameter int SCROLL_STEP = 2,
    parameter int BIRD_X      = 160,
    parameter int GROUND_Y    = 448,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    pipe_field_render_if.slave bus
);
    localparam logic signed [11:0] L_PW      = 12'(PIPE_WIDTH);
    localparam logic signed [11:0] L_STEP    = 12'(SCROLL_STEP);
    localparam logic signed [11:0] L_BIRD    = 12'(BIRD_X);
    localparam logic signed [11:0] L_RESPAWN = 12'sd680;
    localparam logic [9:0]         L_GAP_MIN = 10'd48;
    localparam logic [10:0]        L_GAP_H   = 11'(GAP_HEIGHT);
    localparam logic [9:0]         L_GROUND  = 10'(GROUND_Y);

    localparam logic [7:0] C_SKY    = {3'd2, 3'd6, 2'd3};
    localparam logic [7:0] C_GROUND = {3'd5, 3'd3, 2'd0};
    localparam logic [7:0] C_EDGE   = {3'd0, 3'd3, 2'd0};
    localparam logic [7:0] C_INNER  = {3'd0, 3'd6, 2'd0};

    logic signed [10:0] r_x [2];
    logic [9:0]         r_gap [2];
    logic [7:0]         r_lfsr;
    logic [7:0]         r_score;
    logic [7:0]         r_rgb;
    logic               r_hs, r_vs, r_bright, r_pipe, r_tick;

    logic signed [11:0] w_h;
    logic               w_frame;
    logic [7:0]         w_lfsr_next;
    logic signed [11:0] w_xe [2];
    logic signed [11:0] w_nx [2];
    logic               w_wrap [2];
    logic               w_pass [2];
    logic               w_body [2];
    logic               w_edge [2];
    logic [8:0]         w_score_sum;
    logic [7:0]         w_rgb;
    logic               w_pipe;

    assign w_h         = $signed({2'b00, bus.h_count});
    assign w_frame     = (bus.h_count == 10'd0) && (bus.v_count == 10'd480);
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_xe[i]   = {r_x[i][10], r_x[i]};
            w_nx[i]   = w_xe[i] - L_STEP;
            w_wrap[i] = w_nx[i] <= -L_PW;
            w_pass[i] = ((w_xe[i] + L_PW) > L_BIRD) && ((w_nx[i] + L_PW) <= L_BIRD);
            // Body is the pipe columns minus the open gap rows.
            w_body[i] = (w_h >= w_xe[i]) && (w_h < w_xe[i] + L_PW) &&
                        (({1'b0, bus.v_count} < {1'b0, r_gap[i]}) ||
                         ({1'b0, bus.v_count} >= {1'b0, r_gap[i]} + L_GAP_H));
            w_edge[i] = (w_h == w_xe[i]) || (w_h == w_xe[i] + L_PW - 12'sd1);
        end
    end

    assign w_score_sum = {1'b0, r_score} + {8'd0, w_pass[0]} + {8'd0, w_pass[1]};

    always_comb begin
        w_rgb  = 8'd0;
        w_pipe = 1'b0;
        if (bus.bright) begin
            if (bus.v_count >= L_GROUND) begin
                w_rgb = C_GROUND;
            end else if (w_body[0]) begin
                w_pipe = 1'b1;
                w_rgb  = w_edge[0] ? C_EDGE : C_INNER;
            end else if (w_body[1]) begin
                w_pipe = 1'b1;
                w_rgb  = w_edge[1] ? C_EDGE : C_INNER;
            end else begin
                w_rgb = C_SKY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x[0]   <= 11'sd640;
            r_x[1]   <= 11'sd980;
            r_gap[0] <= 10'd200;
            r_gap[1] <= 10'd200;
            r_lfsr   <= LFSR_SEED;
            r_score  <= 8'd0;
            r_rgb    <= 8'd0;
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_bright <= 1'b0;
            r_pipe   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_rgb    <= w_rgb;
            r_pipe   <= w_pipe;
            r_hs     <= bus.h_sync;
            r_vs     <= bus.v_sync;
            r_bright <= bus.bright;
            r_tick   <= w_frame;
            if (w_frame) begin
                r_lfsr <= w_lfsr_next;
                if (bus.enable) begin
                    // Respawning pipes take the pre-advance LFSR value.
                    for (int i = 0; i < 2; i++) begin
                        if (w_wrap[i]) begin
                            r_x[i]   <= 11'(w_nx[i] + L_RESPAWN);
                            r_gap[i] <= L_GAP_MIN + {2'b00, r_lfsr};
                        end else begin
                            r_x[i] <= w_nx[i][10:0];
                        end
                    end
                    r_score <= w_score_sum[8] ? 8'd255 : w_score_sum[7:0];
                end
            end
        end
    end

    assign bus.red        = r_rgb[7:5];
    assign bus.green      = r_rgb[4:2];
    assign bus.blue       = r_rgb[1:0];
    assign bus.h_sync_out = r_hs;
    assign bus.v_sync_out = r_vs;
    assign bus.bright_out = r_bright;
    assign bus.pipe_pixel = r_pipe;
    assign bus.frame_tick = r_tick;
    assign bus.score      = r_score;
endmodule

// File: tb/tb_pipe_field_render.sv
// Bench for pipe_field_render: compressed frames (two cycles each), a reference
// model feeding an expected-output queue, and a table of pixel probes.
module tb_pipe_field_render;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipe_field_render_if bus ();
    pipe_field_render dut (.clock(clock), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [20:0] exp_q[$];

    int         m_x [2];
    int         m_gap [2];
    int         m_score;
    logic [7:0] m_lfsr;

    typedef struct {
        int         h;
        int         v;
        logic       b;
        logic [7:0] rgb;
        logic       pp;
    } vec_t;
    vec_t tbl [14];

    function automatic void model_reset();
        m_x[0] = 640; m_x[1] = 980;
        m_gap[0] = 200; m_gap[1] = 200;
        m_score = 0;
        m_lfsr = 8'hA5;
    endfunction

    function automatic void model_frame(input logic en);
        logic [7:0] old_l;
        int nx;
        old_l = m_lfsr;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                nx = m_x[i] - 2;
                if ((m_x[i] + 40 > 160) && (nx + 40 <= 160)) m_score = m_score + 1;
                if (nx <= -40) begin
                    m_x[i] = nx + 680;
                    m_gap[i] = 48 + int'(old_l);
                end else begin
                    m_x[i] = nx;
                end
            end
            if (m_score > 255) m_score = 255;
        end
    endfunction

    // Returns {r,g,b,pipe_pixel} for the current model state.
    function automatic logic [8:0] pixel_exp(input int h, input int v, input logic b);
        if (!b) return 9'd0;
        if (v >= 448) return {3'd5, 3'd3, 2'd0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            if (h >= m_x[i] && h < m_x[i] + 40 && (v < m_gap[i] || v >= m_gap[i] + 120)) begin
                if (h == m_x[i] || h == m_x[i] + 39) return {3'd0, 3'd3, 2'd0, 1'b1};
                return {3'd0, 3'd6, 2'd0, 1'b1};
            end
        end
        return {3'd2, 3'd6, 2'd3, 1'b0};
    endfunction

    task automatic check_val(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic drive_cycle(input int h, input int v, input logic b, input logic hs,
                               input logic vs, input logic en, input logic rst);
        logic [8:0]  pix;
        logic        ft;
        logic [20:0] e;
        logic [20:0] got;
        @(negedge clock);
        reset       = rst;
        bus.enable  = en;
        bus.h_count = h[9:0];
        bus.v_count = v[9:0];
        bus.bright  = b;
        bus.h_sync  = hs;
        bus.v_sync  = vs;
        if (rst) begin
            model_reset();
            e = {8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        end else begin
            pix = pixel_exp(h, v, b);
            ft  = (h == 0) && (v == 480);
            if (ft) model_frame(en);
            e = {pix[8:1], hs, vs, b, pix[0], ft, m_score[7:0]};
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got = {bus.red, bus.green, bus.blue, bus.h_sync_out, bus.v_sync_out,
               bus.bright_out, bus.pipe_pixel, bus.frame_tick, bus.score};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL cycle h=%0d v=%0d: got=%h expected=<empty queue>", h, v, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL cycle h=%0d v=%0d: got=%h expected=%h", h, v, got, e);
            end
        end
    endtask

    task automatic run_frames(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            drive_cycle(0, 480, 1'b0, 1'b1, 1'b1, en, 1'b0);
            drive_cycle(5, 481, 1'b0, 1'b1, 1'b0, en, 1'b0);
        end
    endtask

    // Probe the rows bordering the gap of pipe p inside its columns.
    task automatic probe_gap(input int p);
        int h;
        h = m_x[p] + 5;
        if (h < 0) h = 0;
        if (h > 1023) h = 1023;
        drive_cycle(h, m_gap[p] - 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(h, m_gap[p], 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(h, m_gap[p] + 119, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(h, m_gap[p] + 120, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{530, 10, 1'b1, {3'd0, 3'd6, 2'd0}, 1'b1};
        tbl[1]  = '{520, 10, 1'b1, {3'd0, 3'd3, 2'd0}, 1'b1};
        tbl[2]  = '{559, 10, 1'b1, {3'd0, 3'd3, 2'd0}, 1'b1};
        tbl[3]  = '{560, 10, 1'b1, {3'd2, 3'd6, 2'd3}, 1'b0};
        tbl[4]  = '{519, 10, 1'b1, {3'd2, 3'd6, 2'd3}, 1'b0};
        tbl[5]  = '{530, 250, 1'b1, {3'd2, 3'd6, 2'd3}, 1'b0};
        tbl[6]  = '{530, 199, 1'b1, {3'd0, 3'd6, 2'd0}, 1'b1};
        tbl[7]  = '{530, 200, 1'b1, {3'd2, 3'd6, 2'd3}, 1'b0};
        tbl[8]  = '{530, 319, 1'b1, {3'd2, 3'd6, 2'd3}, 1'b0};
        tbl[9]  = '{530, 320, 1'b1, {3'd0, 3'd6, 2'd0}, 1'b1};
        tbl[10] = '{530, 447, 1'b1, {3'd0, 3'd6, 2'd0}, 1'b1};
        tbl[11] = '{530, 448, 1'b1, {3'd5, 3'd3, 2'd0}, 1'b0};
        tbl[12] = '{530, 10, 1'b0, 8'd0, 1'b0};
        tbl[13] = '{100, 10, 1'b1, {3'd2, 3'd6, 2'd3}, 1'b0};

        reset = 1'b1;
        bus.enable = 1'b0; bus.h_count = '0; bus.v_count = '0;
        bus.bright = 1'b0; bus.h_sync = 1'b1; bus.v_sync = 1'b1;
        model_reset();

        drive_cycle(300, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(300, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("reset_score", int'(bus.score), 0);
        check_val("reset_hsync", int'(bus.h_sync_out), 1);

        for (int i = 0; i < 40; i++)
            drive_cycle($urandom_range(0, 799), $urandom_range(0, 479), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

        drive_cycle(0, 480, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("first_tick", int'(bus.frame_tick), 1);
        drive_cycle(1, 480, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("tick_one_cycle", int'(bus.frame_tick), 0);

        run_frames(60, 1'b1);
        for (int i = 0; i < 14; i++) begin
            drive_cycle(tbl[i].h, tbl[i].v, tbl[i].b, 1'b1, 1'b1, 1'b1, 1'b0);
            check_val($sformatf("tbl%0d_rgb", i), int'({bus.red, bus.green, bus.blue}), int'(tbl[i].rgb));
            check_val($sformatf("tbl%0d_pp", i), int'(bus.pipe_pixel), int'(tbl[i].pp));
        end

        run_frames(199, 1'b1);
        check_val("score_f259", int'(bus.score), 0);
        run_frames(1, 1'b1);
        check_val("score_f260", int'(bus.score), 1);
        drive_cycle(120, 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("edge_at_120", int'({bus.red, bus.green, bus.blue}), int'({3'd0, 3'd3, 2'd0}));

        run_frames(80, 1'b1);
        drive_cycle(645, 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("respawn_pipe", int'(bus.pipe_pixel), 1);
        probe_gap(0);

        run_frames(90, 1'b1);
        check_val("score_f430", int'(bus.score), 2);

        run_frames(10, 1'b0);
        check_val("score_frozen", int'(bus.score), 2);
        drive_cycle(465, 460, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("ground_in_pipe", int'({bus.red, bus.green, bus.blue, bus.pipe_pixel}),
                  int'({3'd5, 3'd3, 2'd0, 1'b0}));
        drive_cycle(465, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("frozen_pipe", int'({bus.red, bus.green, bus.blue}), int'({3'd0, 3'd6, 2'd0}));

        run_frames(90, 1'b1);
        probe_gap(1);
        run_frames(160, 1'b1);
        probe_gap(0);
        check_val("score_f680", int'(bus.score), 3);

        drive_cycle(0, 480, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("rst_on_frame_tick", int'(bus.frame_tick), 0);
        check_val("rst_on_frame_score", int'(bus.score), 0);
        drive_cycle(100, 10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_cycle(645, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_cycle(300, 100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("rst_midline_vsync", int'(bus.v_sync_out), 1);

        for (int i = 0; i < 200; i++)
            drive_cycle($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
